// File: rtl/data_memory_arbiter_if.sv
// Connection bundle for data_memory_arbiter: both requester handshakes plus the single-port data memory.
// slave = the arbiter's view; master = requesters and memory together (e.g. a testbench).
interface data_memory_arbiter_if #(
   parameter int ADDR_WIDTH = 5,
   parameter int DATA_WIDTH = 16
);
   logic                  core_req;
   logic                  core_we;
   logic [ADDR_WIDTH-1:0] core_address;
   logic [DATA_WIDTH-1:0] core_wdata;
   logic                  core_ack;
   logic [DATA_WIDTH-1:0] core_rdata;
   logic                  core_stall;

   logic                  comms_req;
   logic                  comms_we;
   logic                  comms_lock;
   logic [ADDR_WIDTH-1:0] comms_address;
   logic [DATA_WIDTH-1:0] comms_wdata;
   logic                  comms_ack;
   logic [DATA_WIDTH-1:0] comms_rdata;

   logic [ADDR_WIDTH-1:0] address_rw;
   logic [DATA_WIDTH-1:0] data_in;
   logic                  memory_write_enable;
   logic [DATA_WIDTH-1:0] data_out;
   logic                  busy;

   modport slave (
      input  core_req, core_we, core_address, core_wdata,
      output core_ack, core_rdata, core_stall,
      input  comms_req, comms_we, comms_lock, comms_address, comms_wdata,
      output comms_ack, comms_rdata,
      output address_rw, data_in, memory_write_enable, busy,
      input  data_out
   );

   modport master (
      output core_req, core_we, core_address, core_wdata,
      input  core_ack, core_rdata, core_stall,
      output comms_req, comms_we, comms_lock, comms_address, comms_wdata,
      input  comms_ack, comms_rdata,
      input  address_rw, data_in, memory_write_enable, busy,
      output data_out
   );
endinterface

// File: rtl/data_memory_arbiter.sv
// Round-robin arbiter sharing one single-port data memory between the core and the comms processor.
// One access per two cycles: grant at the edge, ACCESS drives the memory, DONE returns the ack.
module data_memory_arbiter #(
   parameter int ADDR_WIDTH      = 5,
   parameter int DATA_WIDTH      = 16,
   parameter int MAX_BURST       = 4,
   parameter int BURST_CNT_WIDTH = 3
) (
   input logic                  clk,
   input logic                  rst,
   data_memory_arbiter_if.slave bus
);
   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_DONE   = 2'd2
   } state_t;

   localparam logic OWN_CORE  = 1'b0;
   localparam logic OWN_COMMS = 1'b1;
   localparam logic [BURST_CNT_WIDTH-1:0] BURST_MAX = BURST_CNT_WIDTH'(MAX_BURST);

   state_t                     r_state;
   state_t                     w_state_next;
   logic                       r_last_grant;
   logic                       r_lock;
   logic [BURST_CNT_WIDTH-1:0] r_burst_cnt;
   logic [BURST_CNT_WIDTH-1:0] w_burst_next;
   logic                       r_owner;
   logic                       r_we;
   logic [ADDR_WIDTH-1:0]      r_addr;
   logic [DATA_WIDTH-1:0]      r_wdata;
   logic                       r_core_ack;
   logic                       r_comms_ack;
   logic [DATA_WIDTH-1:0]      r_core_rdata;
   logic [DATA_WIDTH-1:0]      r_comms_rdata;

   logic w_any_req;
   logic w_both_req;
   logic w_lock_active;
   logic w_burst_ok;
   logic w_grant;
   logic w_grant_comms;

   assign w_any_req     = bus.core_req | bus.comms_req;
   assign w_both_req    = bus.core_req & bus.comms_req;
   assign w_lock_active = r_lock & (r_last_grant == OWN_COMMS);
   assign w_burst_ok    = (r_burst_cnt < BURST_MAX);

   always_comb begin
      w_state_next  = r_state;
      w_grant       = 1'b0;
      w_grant_comms = 1'b0;
      w_burst_next  = r_burst_cnt;

      case (r_state)
         S_IDLE, S_DONE: begin
            if (w_any_req) begin
               w_grant      = 1'b1;
               w_state_next = S_ACCESS;
            end else begin
               w_state_next = S_IDLE;
            end
         end
         S_ACCESS: w_state_next = S_DONE;
         default:  w_state_next = S_IDLE;
      endcase

      if (w_both_req)
         w_grant_comms = (w_lock_active & w_burst_ok) | (r_last_grant == OWN_CORE);
      else
         w_grant_comms = bus.comms_req;

      // The grant that carries comms_lock counts too: it is the first grant of the locked burst.
      if (!bus.core_req)
         w_burst_next = '0;
      else if (w_grant && !w_grant_comms)
         w_burst_next = '0;
      else if (w_grant && w_grant_comms && bus.comms_lock && w_burst_ok)
         w_burst_next = r_burst_cnt + BURST_CNT_WIDTH'(1);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state       <= S_IDLE;
         r_last_grant  <= OWN_COMMS;
         r_lock        <= 1'b0;
         r_burst_cnt   <= '0;
         r_owner       <= OWN_CORE;
         r_we          <= 1'b0;
         r_addr        <= '0;
         r_wdata       <= '0;
         r_core_ack    <= 1'b0;
         r_comms_ack   <= 1'b0;
         r_core_rdata  <= '0;
         r_comms_rdata <= '0;
      end else begin
         r_state     <= w_state_next;
         r_burst_cnt <= w_burst_next;
         r_core_ack  <= (r_state == S_ACCESS) && (r_owner == OWN_CORE);
         r_comms_ack <= (r_state == S_ACCESS) && (r_owner == OWN_COMMS);

         if (w_grant) begin
            r_owner      <= w_grant_comms;
            r_last_grant <= w_grant_comms;
            r_we         <= w_grant_comms ? bus.comms_we      : bus.core_we;
            r_addr       <= w_grant_comms ? bus.comms_address : bus.core_address;
            r_wdata      <= w_grant_comms ? bus.comms_wdata   : bus.core_wdata;
            if (w_grant_comms)
               r_lock <= bus.comms_lock;
         end

         if ((r_state == S_ACCESS) && !r_we) begin
            if (r_owner == OWN_COMMS)
               r_comms_rdata <= bus.data_out;
            else
               r_core_rdata  <= bus.data_out;
         end
      end
   end

   // Address/data come straight from the grant latch, so they hold between accesses.
   assign bus.address_rw          = r_addr;
   assign bus.data_in             = r_wdata;
   assign bus.memory_write_enable = (r_state == S_ACCESS) & r_we;
   assign bus.busy                = (r_state != S_IDLE);
   assign bus.core_ack            = r_core_ack;
   assign bus.comms_ack           = r_comms_ack;
   assign bus.core_rdata          = r_core_rdata;
   assign bus.comms_rdata         = r_comms_rdata;
   // Stall is forced low while reset is held so every output reads 0 in reset.
   assign bus.core_stall          = rst & bus.core_req & ~r_core_ack;
endmodule

// File: tb/tb_data_memory_arbiter.sv
// Directed bench for data_memory_arbiter: a transaction-timing model checks every output each cycle,
// and literal expectations pin read data, grant order and the reset-abort case.
module tb_data_memory_arbiter;
   localparam int AW   = 5;
   localparam int DW   = 16;
   localparam int MAXB = 4;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_checks = 0;
   int   n_pass   = 0;

   data_memory_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

   data_memory_arbiter #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_BURST(MAXB), .BURST_CNT_WIDTH(3)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   // ---------------- data memory ----------------
   logic [DW-1:0] tb_mem [32];
   logic          mem_init_done = 1'b0;

   function automatic logic [DW-1:0] init_val(input int i);
      return (i == 5) ? 16'h1234 : 16'(i * 257);
   endfunction

   always @(posedge clk) begin
      if (!mem_init_done) begin
         for (int i = 0; i < 32; i++) tb_mem[i] <= init_val(i);
         mem_init_done <= 1'b1;
      end else if (bus.memory_write_enable) begin
         tb_mem[bus.address_rw] <= bus.data_in;
      end
   end

   assign bus.data_out = tb_mem[bus.address_rw];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
   endtask

   // ---------------- model ----------------
   // Each grant made in cycle c is an access in c+1 and an ack in c+2; the port is free
   // for a new grant in any cycle that is not an access cycle.
   logic [DW-1:0] m_mem [32];
   int            m_cyc = 0;
   int            m_acc_cyc = -10;
   int            m_ack_cyc = -10;
   int            m_run = 0;
   bit            m_last_comms = 1'b1;
   bit            m_lock_req = 1'b0;
   bit            m_g_comms = 1'b0;
   bit            m_g_we = 1'b0;
   logic [AW-1:0] m_addr = '0;
   logic [DW-1:0] m_wdata = '0;
   logic [DW-1:0] m_core_rd = '0;
   logic [DW-1:0] m_comms_rd = '0;
   byte           ack_who [$];
   int            ack_at [$];
   int            mwe_seen = 0;

   task automatic model_cycle();
      bit e_cack, e_mack, e_mwe, e_busy, granted, win, lock_active;
      m_cyc++;
      if (bus.core_ack === 1'b1)  begin ack_who.push_back("C"); ack_at.push_back(m_cyc); end
      if (bus.comms_ack === 1'b1) begin ack_who.push_back("M"); ack_at.push_back(m_cyc); end
      if (bus.memory_write_enable === 1'b1) mwe_seen++;

      if (rst !== 1'b1) begin
         m_last_comms = 1'b1; m_lock_req = 1'b0; m_run = 0;
         m_acc_cyc = -10; m_ack_cyc = -10;
         m_addr = '0; m_wdata = '0; m_core_rd = '0; m_comms_rd = '0;
         chk("rst_core_ack",   32'(bus.core_ack), 32'(0));
         chk("rst_comms_ack",  32'(bus.comms_ack), 32'(0));
         chk("rst_core_rdata", 32'(bus.core_rdata), 32'(0));
         chk("rst_comms_rdata",32'(bus.comms_rdata), 32'(0));
         chk("rst_address_rw", 32'(bus.address_rw), 32'(0));
         chk("rst_data_in",    32'(bus.data_in), 32'(0));
         chk("rst_mwe",        32'(bus.memory_write_enable), 32'(0));
         chk("rst_busy",       32'(bus.busy), 32'(0));
         chk("rst_core_stall", 32'(bus.core_stall), 32'(0));
         return;
      end

      if ((m_cyc == m_ack_cyc) && !m_g_we) begin
         if (m_g_comms) m_comms_rd = m_mem[m_addr];
         else           m_core_rd  = m_mem[m_addr];
      end
      e_mwe  = (m_cyc == m_acc_cyc) && m_g_we;
      e_busy = (m_cyc == m_acc_cyc) || (m_cyc == m_ack_cyc);
      e_cack = (m_cyc == m_ack_cyc) && !m_g_comms;
      e_mack = (m_cyc == m_ack_cyc) && m_g_comms;

      chk("core_ack",    32'(bus.core_ack), 32'(e_cack));
      chk("comms_ack",   32'(bus.comms_ack), 32'(e_mack));
      chk("core_rdata",  32'(bus.core_rdata), 32'(m_core_rd));
      chk("comms_rdata", 32'(bus.comms_rdata), 32'(m_comms_rd));
      chk("address_rw",  32'(bus.address_rw), 32'(m_addr));
      chk("data_in",     32'(bus.data_in), 32'(m_wdata));
      chk("mwe",         32'(bus.memory_write_enable), 32'(e_mwe));
      chk("busy",        32'(bus.busy), 32'(e_busy));
      chk("core_stall",  32'(bus.core_stall), 32'(bus.core_req & !e_cack));

      if (e_mwe) m_mem[m_addr] = m_wdata;

      granted = 1'b0;
      win     = 1'b0;
      if ((m_cyc != m_acc_cyc) && (bus.core_req || bus.comms_req)) begin
         granted = 1'b1;
         if (bus.core_req && bus.comms_req) begin
            lock_active = m_lock_req && m_last_comms;
            win = (lock_active && (m_run < MAXB)) ? 1'b1 : !m_last_comms;
         end else begin
            win = bus.comms_req;
         end
         m_g_comms = win;
         m_g_we    = win ? bus.comms_we : bus.core_we;
         m_addr    = win ? bus.comms_address : bus.core_address;
         m_wdata   = win ? bus.comms_wdata : bus.core_wdata;
         m_acc_cyc = m_cyc + 1;
         m_ack_cyc = m_cyc + 2;
         m_last_comms = win;
         if (win) m_lock_req = bus.comms_lock;
      end

      if (!bus.core_req)                                  m_run = 0;
      else if (granted && !win)                           m_run = 0;
      else if (granted && win && bus.comms_lock && m_run < MAXB) m_run++;
   endtask

   initial begin
      for (int i = 0; i < 32; i++) m_mem[i] = init_val(i);
      forever begin
         @(negedge clk);
         model_cycle();
      end
   end

   // ---------------- stimulus ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) step();
   endtask

   task automatic wait_ack(input bit comms, input int max_cyc);
      int n = 0;
      while ((comms ? bus.comms_ack : bus.core_ack) !== 1'b1 && n < max_cyc) begin
         step();
         n++;
      end
      if (n >= max_cyc) chk(comms ? "comms_ack_timeout" : "core_ack_timeout", 32'(0), 32'(1));
   endtask

   task automatic set_core(input bit req, input bit we, input int addr, input logic [DW-1:0] wd);
      bus.core_req = req; bus.core_we = we; bus.core_address = AW'(addr); bus.core_wdata = wd;
   endtask

   task automatic set_comms(input bit req, input bit we, input bit lock, input int addr,
                            input logic [DW-1:0] wd);
      bus.comms_req = req; bus.comms_we = we; bus.comms_lock = lock;
      bus.comms_address = AW'(addr); bus.comms_wdata = wd;
   endtask

   task automatic check_seq(input string tag, input int start, input string exp);
      chk({tag, "_len"}, 32'(ack_who.size() - start), 32'(exp.len()));
      for (int k = 0; k < exp.len() && (start + k) < ack_who.size(); k++)
         chk(tag, 32'(ack_who[start + k]), 32'(exp.getc(k)));
      for (int k = 1; k < exp.len() && (start + k) < ack_at.size(); k++)
         chk({tag, "_gap"}, 32'(ack_at[start + k] - ack_at[start + k - 1]), 32'(2));
   endtask

   initial begin
      int start, n, guard, m0;
      set_core(1'b1, 1'b0, 1, 16'h0000);
      set_comms(1'b1, 1'b0, 1'b0, 2, 16'h0000);
      rst = 1'b0;

      // 1: reset with both requests high, then core wins the first tie
      repeat (3) @(posedge clk);
      #1;
      chk("t1_busy_in_reset",  32'(bus.busy), 32'(0));
      chk("t1_stall_in_reset", 32'(bus.core_stall), 32'(0));
      rst = 1'b1;
      wait_ack(1'b0, 8);
      chk("t1_no_earlier_ack", 32'(ack_who.size()), 32'(0));
      chk("t1_core_rdata",     32'(bus.core_rdata), 32'(16'h0101));
      chk("t1_comms_waits",    32'(bus.comms_ack), 32'(0));
      bus.core_req = 1'b0;
      wait_ack(1'b1, 8);
      chk("t1_comms_rdata",    32'(bus.comms_rdata), 32'(16'h0202));
      bus.comms_req = 1'b0;
      idle(3);

      // 2: core read of address 5, exact latency
      set_core(1'b1, 1'b0, 5, 16'h0000);
      #1;
      chk("t2_stall_c0", 32'(bus.core_stall), 32'(1));
      chk("t2_busy_c0",  32'(bus.busy), 32'(0));
      step();
      chk("t2_addr_c1",  32'(bus.address_rw), 32'(5));
      chk("t2_stall_c1", 32'(bus.core_stall), 32'(1));
      chk("t2_ack_c1",   32'(bus.core_ack), 32'(0));
      step();
      chk("t2_ack_c2",   32'(bus.core_ack), 32'(1));
      chk("t2_rdata_c2", 32'(bus.core_rdata), 32'(16'h1234));
      bus.core_req = 1'b0;
      #1;
      chk("t2_stall_off", 32'(bus.core_stall), 32'(0));
      idle(3);

      // 3: core write 31, comms reads it back in the core's ack cycle
      m0 = mwe_seen;
      set_core(1'b1, 1'b1, 31, 16'hBEEF);
      wait_ack(1'b0, 6);
      bus.core_req = 1'b0;
      set_comms(1'b1, 1'b0, 1'b0, 31, 16'h5555);
      wait_ack(1'b1, 6);
      chk("t3_comms_rdata", 32'(bus.comms_rdata), 32'(16'hBEEF));
      bus.comms_req = 1'b0;
      idle(3);
      chk("t3_mwe_cycles", 32'(mwe_seen - m0), 32'(1));
      chk("t3_mem31",      32'(tb_mem[31]), 32'(16'hBEEF));

      // 4: both requesting, no lock -> strict alternation
      start = ack_who.size();
      set_core(1'b1, 1'b0, 10, 16'h0000);
      set_comms(1'b1, 1'b0, 1'b0, 11, 16'h0000);
      n = 0; guard = 0;
      while (n < 8 && guard < 40) begin
         step(); guard++;
         if (bus.core_ack === 1'b1 || bus.comms_ack === 1'b1) n++;
      end
      chk("t4_ack_count", 32'(n), 32'(8));
      bus.comms_req = 1'b0;
      wait_ack(1'b0, 6);
      bus.core_req = 1'b0;
      idle(3);
      check_seq("t4_seq", start, "CMCMCMCMC");

      // 5: comms lock limits the burst to MAX_BURST grants while core waits
      start = ack_who.size();
      set_core(1'b1, 1'b0, 12, 16'h0000);
      set_comms(1'b1, 1'b0, 1'b1, 13, 16'h0000);
      n = 0; guard = 0;
      while (n < 6 && guard < 40) begin
         step(); guard++;
         if (bus.core_ack === 1'b1 || bus.comms_ack === 1'b1) n++;
      end
      chk("t5_ack_count", 32'(n), 32'(6));
      set_comms(1'b0, 1'b0, 1'b0, 13, 16'h0000);
      wait_ack(1'b0, 6);
      bus.core_req = 1'b0;
      idle(3);
      check_seq("t5_seq", start, "MMMMCMC");

      // 6: reset during a core write access aborts it
      start = ack_who.size();
      set_core(1'b1, 1'b1, 3, 16'hDEAD);
      step();
      chk("t6_mwe_before_rst", 32'(bus.memory_write_enable), 32'(1));
      rst = 1'b0;
      bus.core_req = 1'b0;
      #1;
      chk("t6_mwe_in_rst", 32'(bus.memory_write_enable), 32'(0));
      idle(2);
      rst = 1'b1;
      idle(3);
      chk("t6_mem3_kept", 32'(tb_mem[3]), 32'(16'h0303));
      chk("t6_no_ack",    32'(ack_who.size() - start), 32'(0));
      set_core(1'b1, 1'b1, 3, 16'hDEAD);
      wait_ack(1'b0, 6);
      bus.core_req = 1'b0;
      idle(2);
      chk("t6_mem3_reissued", 32'(tb_mem[3]), 32'(16'hDEAD));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
      $fatal(1);
   end
endmodule
